ecall_ctrl: RTL and testbench
=============================

# ecall_ctrl

Environment-call controller sitting directly upstream of the program counter: it watches the fetched instruction, recognises `ecall`, and services it against board I/O. It drives the PC's `stop_flag` so the PC holds on the `ecall` while a service is pending. It also returns read data to register `a0` and latches displayed values for the seven-segment/LED driver. Services:

- print-int: non-blocking
- read-int: blocks until the confirm button is pressed
- exit: halts until reset

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 2_000_000: cycles the button must be stable before a level change is accepted (20 ms at 100 MHz).

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst`  in  32  instruction currently presented by the PC/ROM.
- `a7`  in  32  register x17 read value (service code).
- `a0`  in  32  register x10 read value (argument).
- `sw`  in  16  board switches.
- `btn_confirm`  in  1  raw, undebounced confirm button, active-high.
- `stop_flag`  out  1  to PC; 1 holds the PC.
- `wb_en`  out  1  register-file write enable for x10.
- `wb_data`  out  32  value written to x10.
- `disp_data`  out  32  value shown on the display.
- `halted`  out  1  exit service taken.

## Operation
- `ecall` detect: `inst == 32'h0000_0073`. Other instructions are ignored.
- Service codes (`a7`): 1 = PRINT_INT, 5 = READ_INT, 10 = EXIT. Any other code is a no-op, with no stall.
- States: IDLE, WAIT_REL, WAIT_PRESS, WRITEBACK, RESUME, HALT.
- IDLE:
  - ecall with PRINT_INT: `disp_data <= a0`; stay in IDLE.
  - ecall with READ_INT: → WAIT_REL.
  - ecall with EXIT: → HALT.
- WAIT_REL: → WAIT_PRESS once the debounced button is 0. This rejects a press still held from a previous read.
- WAIT_PRESS: on the debounced rising edge, latch `wb_data <= {16'b0, sw}` and `disp_data <= {16'b0, sw}`; → WRITEBACK.
- WRITEBACK: `wb_en = 1` for exactly this cycle; → RESUME.
- RESUME: one cycle during which `ecall` is ignored, letting the PC step past it; → IDLE.
- HALT: absorbing; `halted = 1`. Only `rst_n` exits.
- `stop_flag` is combinational:
  - 1 in WAIT_REL, WAIT_PRESS, WRITEBACK and HALT.
  - 1 in IDLE when the `ecall` decode gives READ_INT or EXIT.
  - 0 otherwise, including RESUME and PRINT_INT.
- Debounce:
  - Synchronise `btn_confirm` through 2 flops.
  - A counter runs while the synchronised level differs from the stable level and clears when they match.
  - At `DEBOUNCE_CYCLES - 1` the stable level takes the new value.
  - Rising edge = stable level 0→1, registered one cycle.
  - The counter width is `$clog2(DEBOUNCE_CYCLES+1)`; the counter saturates and never wraps.

## Timing
- Reset values: state IDLE, `stop_flag` 0 (IDLE with no `ecall`), `wb_en` 0, `wb_data` 0, `disp_data` 0, `halted` 0, debounce counter 0, stable level 0, sync flops 0.
- `stop_flag` must settle within the same cycle `inst` changes, ahead of the PC's negedge update. It is therefore purely combinational from state, `inst` and `a7`.
- PRINT_INT:
  - `disp_data` updates at the first posedge with the `ecall` present.
  - If the PC presents the same `ecall` for several cycles, `disp_data` is rewritten with the same value, which is harmless.
- READ_INT latency, from stable rising edge: WRITEBACK 1 cycle, then RESUME 1 cycle, then IDLE.
  - Minimum stall = 2 + 2 + `DEBOUNCE_CYCLES` + 2 cycles.
- Button edge coinciding with WAIT_REL exit: the edge is ignored until WAIT_PRESS is entered. No edge is queued.
- Reset mid-service: any state → IDLE immediately, asynchronously. `wb_en` drops without completing the write.
- `a7`/`a0` are sampled only in IDLE. Later changes do not affect a service in progress.

## Structure
- Package `ecall_pkg`: `ECALL_INST`, the `SVC_PRINT_INT`/`SVC_READ_INT`/`SVC_EXIT` codes, and the state enum.
- Sub-module `btn_debounce`:
  - Instance parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst_n`, raw in, stable level out, rise pulse out.
- Target size: FSM plus output registers ~150 lines; debounce ~60 lines.

## Test plan
Use `DEBOUNCE_CYCLES=4` throughout.
- Reset: hold `rst_n=0`, drive `inst=ecall`, `a7=5` → `stop_flag=1` combinationally; all registered outputs 0; state IDLE after release.
- PRINT_INT: `inst=0x00000073`, `a7=1`, `a0=0x1234ABCD` → `disp_data=0x1234ABCD` after 1 posedge; `stop_flag=0` throughout; `wb_en` never asserts.
- READ_INT: `a7=5`, `sw=0x00F0`, button held high on entry → waits for release; then a 10-cycle press → exactly one `wb_en` pulse with `wb_data=0x000000F0`, followed by a `stop_flag=0` RESUME cycle.
- Bounce rejection: during WAIT_PRESS, toggle the button 1-2-1-3 cycles (below the threshold) → no `wb_en`, `stop_flag` stays 1.
- EXIT: `a7=10` → `halted=1` and `stop_flag=1` for 50+ cycles with arbitrary `inst`/`a7`; assert `rst_n=0` → both clear.
- Non-service: `inst=ecall`, `a7=7`, and separately `inst=0x00000013` with `a7=5` → `stop_flag=0` and no state change.

Source files
------------

// File: rtl/ecall_pkg.sv
// Shared constants and state encoding for the environment-call controller.
package ecall_pkg;

  localparam logic [31:0] ECALL_INST    = 32'h0000_0073;
  localparam logic [31:0] SVC_PRINT_INT = 32'd1;
  localparam logic [31:0] SVC_READ_INT  = 32'd5;
  localparam logic [31:0] SVC_EXIT      = 32'd10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_REL   = 3'd1,
    ST_WAIT_PRESS = 3'd2,
    ST_WRITEBACK  = 3'd3,
    ST_RESUME     = 3'd4,
    ST_HALT       = 3'd5
  } state_t;

  function automatic logic is_ecall(input logic [31:0] word);
    return (word == ECALL_INST);
  endfunction

endpackage

// File: rtl/ecall_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stability counter; emits the accepted level
// and a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          rise_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, count disagreement time, accept the new level when it lasts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      rise_r  <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r >= CNT_LAST) begin
          level_r <= sync2_r;
          rise_r  <= sync2_r;
          cnt_r   <= '0;
        end else if (cnt_r != CNT_MAX) begin
          cnt_r <= cnt_r + CNT_ONE;
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/ecall_ctrl.sv
// Recognises ecall at fetch, stalls the PC while a service is pending and
// drives the x10 writeback and display registers.
module ecall_ctrl
  import ecall_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [31:0] a7,
  input  logic [31:0] a0,
  input  logic [15:0] sw,
  input  logic        btn_confirm,
  output logic        stop_flag,
  output logic        wb_en,
  output logic [31:0] wb_data,
  output logic [31:0] disp_data,
  output logic        halted
);

  state_t state_r;
  logic   btn_level_s;
  logic   btn_rise_s;
  logic   ecall_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_confirm),
    .level (btn_level_s),
    .rise  (btn_rise_s)
  );

  assign ecall_s = is_ecall(inst);

  // Stall decode must be combinational so the PC sees it before its negedge update.
  always_comb begin
    stop_flag = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ecall_s && ((a7 == SVC_READ_INT) || (a7 == SVC_EXIT))) begin
          stop_flag = 1'b1;
        end else begin
          stop_flag = 1'b0;
        end
      end
      ST_WAIT_REL,
      ST_WAIT_PRESS,
      ST_WRITEBACK,
      ST_HALT:   stop_flag = 1'b1;
      ST_RESUME: stop_flag = 1'b0;
      default:   stop_flag = 1'b0;
    endcase
  end

  // Service FSM with registered writeback, display and halt outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      wb_en     <= 1'b0;
      wb_data   <= 32'h0000_0000;
      disp_data <= 32'h0000_0000;
      halted    <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ecall_s) begin
            case (a7)
              SVC_PRINT_INT: disp_data <= a0;
              SVC_READ_INT:  state_r   <= ST_WAIT_REL;
              SVC_EXIT: begin
                state_r <= ST_HALT;
                halted  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        // A press still held from an earlier read must be released first.
        ST_WAIT_REL: begin
          if (!btn_level_s) begin
            state_r <= ST_WAIT_PRESS;
          end
        end
        ST_WAIT_PRESS: begin
          if (btn_rise_s) begin
            wb_data   <= {16'h0000, sw};
            disp_data <= {16'h0000, sw};
            wb_en     <= 1'b1;
            state_r   <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: state_r <= ST_RESUME;
        ST_RESUME:    state_r <= ST_IDLE;
        ST_HALT:      halted  <= 1'b1;
        default:      state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecall_ctrl.sv
// Directed bench for ecall_ctrl with a short debounce window.
module tb_ecall_ctrl;

  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic [31:0] a7;
  logic [31:0] a0;
  logic [15:0] sw;
  logic        btn_confirm;
  logic        stop_flag;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [31:0] disp_data;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;
  logic prev_wb;
  int durs [4] = '{1, 2, 1, 3};

  always #5 clk = ~clk;

  ecall_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst        (inst),
    .a7          (a7),
    .a0          (a0),
    .sw          (sw),
    .btn_confirm (btn_confirm),
    .stop_flag   (stop_flag),
    .wb_en       (wb_en),
    .wb_data     (wb_data),
    .disp_data   (disp_data),
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a READ_INT ecall presented
    rst_n = 1'b0; inst = ECALL; a7 = 32'd5; a0 = 32'h0; sw = 16'h0; btn_confirm = 1'b0;
    #3;
    chk("rst_stop_comb", stop_flag, 32'd1);
    chk("rst_wb_en", wb_en, 32'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_disp", disp_data, 32'h0);
    chk("rst_halted", halted, 32'd0);
    cyc(2);
    inst = NOP; a7 = 32'd0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("idle_after_rst", stop_flag, 32'd0);

    // Unknown service code: no stall
    inst = ECALL; a7 = 32'd7;
    #1 chk("svc7_stop", stop_flag, 32'd0);
    cyc(3);
    chk("svc7_stop_later", stop_flag, 32'd0);
    chk("svc7_wb_en", wb_en, 32'd0);
    chk("svc7_halted", halted, 32'd0);
    inst = NOP; a7 = 32'd0;
    #1 chk("svc7_state_idle", stop_flag, 32'd0);

    // Non-ecall instruction with a READ_INT code
    cyc(1);
    inst = NOP; a7 = 32'd5;
    #1 chk("nop5_stop", stop_flag, 32'd0);
    cyc(3);
    chk("nop5_stop_later", stop_flag, 32'd0);
    a7 = 32'd0;
    #1 chk("nop5_state_idle", stop_flag, 32'd0);

    // PRINT_INT
    cyc(1);
    inst = ECALL; a7 = 32'd1; a0 = 32'h1234_ABCD;
    #1 chk("print_stop", stop_flag, 32'd0);
    cyc(1);
    chk("print_disp", disp_data, 32'h1234_ABCD);
    chk("print_wb_en", wb_en, 32'd0);
    chk("print_stop2", stop_flag, 32'd0);
    cyc(2);
    chk("print_wb_en2", wb_en, 32'd0);
    inst = NOP; a0 = 32'hDEAD_BEEF;
    cyc(2);
    chk("print_disp_hold", disp_data, 32'h1234_ABCD);

    // READ_INT with the button already held
    btn_confirm = 1'b1;
    cyc(10);
    inst = ECALL; a7 = 32'd5; sw = 16'h00F0;
    #1 chk("read_stop_idle", stop_flag, 32'd1);
    cyc(1);
    a7 = 32'd1; a0 = 32'h0000_0055;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("wait_rel_stop", stop_flag, 32'd1);
      chk("wait_rel_wb_en", wb_en, 32'd0);
    end
    chk("wait_rel_disp", disp_data, 32'h1234_ABCD);
    btn_confirm = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      chk("release_stop", stop_flag, 32'd1);
      chk("release_wb_en", wb_en, 32'd0);
    end

    // Bounce shorter than the debounce window
    for (int i = 0; i < 4; i++) begin
      btn_confirm = (i % 2 == 0);
      for (int j = 0; j < durs[i]; j++) begin
        cyc(1);
        chk("bounce_stop", stop_flag, 32'd1);
        chk("bounce_wb_en", wb_en, 32'd0);
      end
    end
    btn_confirm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("bounce_settle_stop", stop_flag, 32'd1);
      chk("bounce_settle_wb_en", wb_en, 32'd0);
    end

    // 10-cycle press: one writeback pulse, then a RESUME cycle
    pulses = 0;
    prev_wb = 1'b0;
    for (int i = 0; i < 25; i++) begin
      btn_confirm = (i < 10);
      cyc(1);
      if (prev_wb) begin
        chk("resume_stop", stop_flag, 32'd0);
        inst = NOP;
      end
      if (wb_en === 1'b1) begin
        pulses++;
        chk("read_wb_data", wb_data, 32'h0000_00F0);
        chk("writeback_stop", stop_flag, 32'd1);
      end
      prev_wb = wb_en;
    end
    chk("read_pulse_count", pulses, 32'd1);
    chk("read_disp", disp_data, 32'h0000_00F0);
    chk("read_back_idle", stop_flag, 32'd0);

    // EXIT: absorbing until reset
    inst = ECALL; a7 = 32'd10;
    #1 chk("exit_stop_idle", stop_flag, 32'd1);
    cyc(1);
    chk("exit_halted", halted, 32'd1);
    for (int i = 0; i < 55; i++) begin
      inst = $urandom;
      a7 = 32'($urandom_range(0, 15));
      cyc(1);
      chk("halt_halted", halted, 32'd1);
      chk("halt_stop", stop_flag, 32'd1);
    end
    inst = NOP;
    rst_n = 1'b0;
    #1;
    chk("exit_rst_halted", halted, 32'd0);
    chk("exit_rst_stop", stop_flag, 32'd0);
    chk("exit_rst_wb_data", wb_data, 32'h0);
    chk("exit_rst_disp", disp_data, 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("post_exit_idle", stop_flag, 32'd0);
    chk("post_exit_halted", halted, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
